fetch_unit: RTL

Instruction-fetch stage sitting directly upstream of instructionmemory. It owns the program counter and drives the memory address. It captures the returned instruction into an IF/ID pipeline register for the decoder. It handles sequential fetch, branch and jump redirects, stalls from the hazard unit, and flushes.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_pc_reg.sv | 41 ++++
 rtl/fetch_unit.sv | 45 ++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, IF/ID record type and jump target helper for the fetch stage
package fetch_pkg;
  localparam logic [31:0] PC_INC = 32'd4;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;
  function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4, input logic [25:0] index);
    return {pc_plus4[31:28], index, 2'b00};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: control inputs, instruction memory port and IF/ID outputs of the fetch stage
interface fetch_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        misaligned;
  modport master (
    input  stall, flush, branch_taken, branch_target, jump, jump_index, imem_instruction,
    output imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, misaligned
  );
  modport slave (
    output stall, flush, branch_taken, branch_target, jump, jump_index, imem_instruction,
    input  imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, misaligned
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter, next-PC priority mux and misaligned-redirect flag
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] if_pc_plus4,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);
  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;
  always_comb begin
    pc_plus4     = pc_q + PC_INC;
    // Branch resolves for an older instruction than the jump, so it wins
    pc_d         = branch_taken ? {branch_target[31:2], 2'b00}
                 : jump         ? jump_target(if_pc_plus4, jump_index)
                 : stall        ? pc_q
                 :                pc_plus4;
    misaligned_d = branch_taken && (branch_target[1:0] != 2'b00);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end
  assign pc         = pc_q;
  assign misaligned = misaligned_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving instruction memory and the IF/ID pipeline register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);
  logic [31:0] pc, pc_plus4;
  logic        misaligned;
  logic        bubble;
  ifid_t       ifid_q, ifid_d;
  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk           (clk),
    .reset         (reset),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_index    (bus.jump_index),
    .if_pc_plus4   (ifid_q.pc_plus4),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misaligned    (misaligned)
  );
  always_comb begin
    bubble = bus.branch_taken || bus.jump || bus.flush;
    ifid_d = bubble    ? ifid_t'{instr: NOP_WORD, pc: pc, pc_plus4: pc_plus4, valid: 1'b0}
           : bus.stall ? ifid_q
           :             ifid_t'{instr: bus.imem_instruction, pc: pc, pc_plus4: pc_plus4, valid: 1'b1};
  end
  always_ff @(posedge clk) begin
    if (reset) ifid_q <= ifid_t'{instr: NOP_WORD, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
    else       ifid_q <= ifid_d;
  end
  assign bus.imem_addr   = pc;
  assign bus.if_instr    = ifid_q.instr;
  assign bus.if_pc       = ifid_q.pc;
  assign bus.if_pc_plus4 = ifid_q.pc_plus4;
  assign bus.if_valid    = ifid_q.valid;
  assign bus.misaligned  = misaligned;
endmodule
